// File: rtl/svf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// svf_ctrl_pkg
// Shared definitions for the SVF bias-DAC control link: frame geometry, the
// serial transmitter state encoding and the {Q, fc} frame-packing helper.
// -----------------------------------------------------------------------------
package svf_ctrl_pkg;

   localparam int FRAME_BITS = 8;
   localparam int FC_BITS    = 4;
   localparam int Q_BITS     = 4;

   typedef enum logic [2:0] {
      IDLE,
      BIT_LO,
      BIT_HI,
      GAP,
      LOAD
   } state_t;

   // Q occupies the upper nibble so it is shifted out first.
   function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [Q_BITS-1:0]  q,
                                                        input logic [FC_BITS-1:0] fc);
      return {q, fc};
   endfunction

endpackage

// File: rtl/svf_bias_spi_tx_if.sv
// -----------------------------------------------------------------------------
// svf_bias_spi_tx_if
// Write handshake into the bias SPI transmitter.
//   wr_valid : a word is offered on wr_fc / wr_q
//   wr_ready : the transmitter accepts a word on this cycle's rising edge
//   wr_fc    : fc code, frame bits [3:0]
//   wr_q     : Q code, frame bits [7:4]
// master = word producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface svf_bias_spi_tx_if;
   import svf_ctrl_pkg::*;

   logic               wr_valid;
   logic               wr_ready;
   logic [FC_BITS-1:0] wr_fc;
   logic [Q_BITS-1:0]  wr_q;

   modport master (output wr_valid, output wr_fc, output wr_q, input  wr_ready);
   modport slave  (input  wr_valid, input  wr_fc, input  wr_q, output wr_ready);

endinterface

// File: rtl/svf_phase_timer.sv
// -----------------------------------------------------------------------------
// svf_phase_timer
// Measures one SCK/LOAD phase: HALF clk cycles from the cycle after restart.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : start a new phase (loads HALF-1)
//   expire     : high in the last cycle of a phase, for one cycle only
// The owner restarts the timer in the expiring cycle to chain phases; if it
// does not, the timer stops and expire stays low.
// -----------------------------------------------------------------------------
module svf_phase_timer #(
   parameter int unsigned HALF = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic expire
);

   localparam logic [7:0] RELOAD = 8'(HALF - 1);

   logic [7:0] count_q;
   logic       running_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (restart) begin
         count_q   <= RELOAD;
         running_q <= 1'b1;
      end else if (count_q != 8'd0) begin
         count_q   <= count_q - 8'd1;
      end else begin
         running_q <= 1'b0;
      end
   end

   assign expire = running_q && (count_q == 8'd0);

endmodule

// File: rtl/svf_bias_spi_tx.sv
// -----------------------------------------------------------------------------
// svf_bias_spi_tx
// Serialises a {Q, fc} word into the SDI/SCK/LOAD frame of the SVF bias shift
// register: eight bits MSB first (one SCK rise each), a GAP phase, then a LOAD
// phase. A one-entry holding buffer accepts the next word during a frame so
// frames can run back to back with no idle cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : write handshake (slave side), wr_ready = !pend_valid
//   sdi        : serial data, changes only while sck is low
//   sck        : serial clock, HALF cycles low then HALF cycles high per bit
//   load       : latch strobe, high for HALF cycles after the GAP phase
//   busy       : a frame is in progress
//   done       : one-cycle pulse in the cycle after the last LOAD cycle
// HALF = clk cycles per phase, 2..255.
// -----------------------------------------------------------------------------
module svf_bias_spi_tx
   import svf_ctrl_pkg::*;
#(
   parameter int unsigned HALF = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   svf_bias_spi_tx_if.slave       wr,
   output logic                   sdi,
   output logic                   sck,
   output logic                   load,
   output logic                   busy,
   output logic                   done
);

   if (HALF < 2 || HALF > 255) begin : g_half_check
      $error("svf_bias_spi_tx: HALF must be within 2..255");
   end

   localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic                  pend_valid_q;
   logic [FRAME_BITS-1:0] pend_word_q;

   logic                  accept;
   logic                  pend_load;
   logic                  consume;
   logic                  restart;
   logic                  expire;
   logic                  frame_end;
   logic [FRAME_BITS-1:0] word_in;
   logic                  in_bit;
   logic                  sdi_d, sck_d, load_d, busy_d;

   svf_phase_timer #(.HALF(HALF)) u_phase_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .expire  (expire)
   );

   assign wr.wr_ready = ~pend_valid_q;
   assign accept      = wr.wr_valid & ~pend_valid_q;
   assign word_in     = pack_frame(wr.wr_q, wr.wr_fc);
   // An idle transmitter takes the word straight into the shifter; otherwise
   // it lands in the holding buffer.
   assign pend_load   = accept && (state_q != IDLE);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      restart   = 1'b0;
      consume   = 1'b0;
      frame_end = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pend_valid_q || accept) begin
               state_d   = BIT_LO;
               shift_d   = pend_valid_q ? pend_word_q : word_in;
               bit_cnt_d = LAST_BIT;
               restart   = 1'b1;
               consume   = pend_valid_q;
            end
         end
         BIT_LO: begin
            if (expire) begin
               state_d = BIT_HI;
               restart = 1'b1;
            end
         end
         BIT_HI: begin
            if (expire) begin
               restart = 1'b1;
               if (bit_cnt_q != 3'd0) begin
                  shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  state_d   = BIT_LO;
               end else begin
                  state_d   = GAP;
               end
            end
         end
         GAP: begin
            if (expire) begin
               state_d = LOAD;
               restart = 1'b1;
            end
         end
         LOAD: begin
            if (expire) begin
               frame_end = 1'b1;
               if (pend_valid_q) begin
                  state_d   = BIT_LO;
                  shift_d   = pend_word_q;
                  bit_cnt_d = LAST_BIT;
                  restart   = 1'b1;
                  consume   = 1'b1;
               end else begin
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it, so
   // they change on the same edge as the state with no input-to-output path.
   // shift_d only moves when leaving BIT_HI, which keeps sdi stable while sck=1.
   assign in_bit = (state_d == BIT_LO) || (state_d == BIT_HI);
   assign sdi_d  = in_bit & shift_d[FRAME_BITS-1];
   assign sck_d  = (state_d == BIT_HI);
   assign load_d = (state_d == LOAD);
   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         pend_valid_q <= 1'b0;
         // NOTE: the holding word is guarded by pend_valid and would not need a
         // reset; it is cleared anyway so the post-reset state is deterministic.
         pend_word_q  <= '0;
         sdi          <= 1'b0;
         sck          <= 1'b0;
         load         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         sdi       <= sdi_d;
         sck       <= sck_d;
         load      <= load_d;
         busy      <= busy_d;
         done      <= frame_end;
         // A refill in the consuming cycle keeps the buffer full.
         if (pend_load) begin
            pend_valid_q <= 1'b1;
            pend_word_q  <= word_in;
         end else if (consume) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_svf_bias_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_svf_bias_spi_tx
// Two transmitters (HALF=2 and HALF=5) are compared every cycle against a
// frame-position model, and each feeds a clk-sampled copy of the bias shift
// register receiver. Directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_svf_bias_spi_tx;

   localparam int H0   = 2;
   localparam int H1   = 5;
   localparam int NREC = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   logic       drv_valid [2];
   logic [3:0] drv_fc    [2];
   logic [3:0] drv_q     [2];

   logic [1:0] rdy, sdi_w, sck_w, load_w, busy_w, done_w;

   svf_bias_spi_tx_if bus0 ();
   svf_bias_spi_tx_if bus1 ();

   assign bus0.wr_valid = drv_valid[0];
   assign bus0.wr_fc    = drv_fc[0];
   assign bus0.wr_q     = drv_q[0];
   assign bus1.wr_valid = drv_valid[1];
   assign bus1.wr_fc    = drv_fc[1];
   assign bus1.wr_q     = drv_q[1];
   assign rdy[0]        = bus0.wr_ready;
   assign rdy[1]        = bus1.wr_ready;

   svf_bias_spi_tx #(.HALF(H0)) dut0 (
      .clk (clk), .rst_n (rst_n), .wr (bus0),
      .sdi (sdi_w[0]), .sck (sck_w[0]), .load (load_w[0]),
      .busy (busy_w[0]), .done (done_w[0])
   );

   svf_bias_spi_tx #(.HALF(H1)) dut1 (
      .clk (clk), .rst_n (rst_n), .wr (bus1),
      .sdi (sdi_w[1]), .sck (sck_w[1]), .load (load_w[1]),
      .busy (busy_w[1]), .done (done_w[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int half_of(input int i);
      return (i == 0) ? H0 : H1;
   endfunction

   // ---------------- behavioural model: frame position per instance ----------
   bit         m_active [2] = '{1'b0, 1'b0};
   int         m_pos    [2] = '{0, 0};
   logic [7:0] m_word   [2] = '{8'h00, 8'h00};
   logic [7:0] m_pend   [2] = '{8'h00, 8'h00};
   bit         m_pend_v [2] = '{1'b0, 1'b0};
   bit         m_done   [2] = '{1'b0, 1'b0};

   task automatic model_step(input int i);
      int         h;
      bit         acc;
      logic [7:0] w;
      h   = half_of(i);
      w   = {drv_q[i], drv_fc[i]};
      acc = drv_valid[i] && !m_pend_v[i];
      m_done[i] = 1'b0;
      if (m_active[i]) begin
         if (m_pos[i] == 18 * h - 1) begin
            m_done[i] = 1'b1;
            if (m_pend_v[i]) begin
               m_word[i]   = m_pend[i];
               m_pos[i]    = 0;
               m_pend_v[i] = 1'b0;
            end else begin
               m_active[i] = 1'b0;
            end
         end else begin
            m_pos[i]++;
         end
         if (acc) begin
            m_pend[i]   = w;
            m_pend_v[i] = 1'b1;
         end
      end else if (m_pend_v[i]) begin
         m_word[i]   = m_pend[i];
         m_pos[i]    = 0;
         m_active[i] = 1'b1;
         m_pend_v[i] = 1'b0;
      end else if (acc) begin
         m_word[i]   = w;
         m_pos[i]    = 0;
         m_active[i] = 1'b1;
      end
   endtask

   // {wr_ready, sdi, sck, load, busy, done} for the current cycle.
   function automatic logic [5:0] model_out(input int i);
      int   h, p;
      logic s, c, l, b;
      h = half_of(i);
      p = m_pos[i];
      s = 1'b0; c = 1'b0; l = 1'b0; b = 1'b0;
      if (m_active[i]) begin
         b = 1'b1;
         if (p < 16 * h) begin
            c = ((p / h) % 2) == 1;
            s = m_word[i][7 - p / (2 * h)];
         end else begin
            l = (p >= 17 * h);
         end
      end
      return {!m_pend_v[i], s, c, l, b, m_done[i]};
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_pos[i]    = 0;
            m_pend_v[i] = 1'b0;
            m_done[i]   = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // ---------------- receiver copies and per-cycle compare --------------------
   logic [7:0] rx_sr    [2] = '{8'h00, 8'h00};
   logic [3:0] rx_fc    [2] = '{4'h0, 4'h0};
   logic [3:0] rx_q     [2] = '{4'h0, 4'h0};
   logic       rx_psck  [2] = '{1'b0, 1'b0};
   logic       rx_pload [2] = '{1'b0, 1'b0};
   logic       prev_sdi [2] = '{1'b0, 1'b0};
   int         rise_cnt [2] = '{0, 0};
   int         load_cnt [2] = '{0, 0};
   int         done_cnt [2] = '{0, 0};
   int         rise_cyc [2][NREC];
   int         done_cyc [2][NREC];
   logic [7:0] latch_w  [2][NREC];

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("outs%0d", i),
               32'({rdy[i], sdi_w[i], sck_w[i], load_w[i], busy_w[i], done_w[i]}),
               32'(model_out(i)));
         a_no_load_sck: assert (!(load_w[i] && sck_w[i]));
         check($sformatf("load_and_sck%0d", i), 32'(load_w[i] & sck_w[i]), 0);
         if (rx_psck[i] && sck_w[i])
            check($sformatf("sdi_stable%0d", i), 32'(sdi_w[i]), 32'(prev_sdi[i]));
         if (sck_w[i] && !rx_psck[i]) begin
            rx_sr[i] = {rx_sr[i][6:0], sdi_w[i]};
            if (rise_cnt[i] < NREC) rise_cyc[i][rise_cnt[i]] = cyc;
            rise_cnt[i]++;
         end
         if (load_w[i] && !rx_pload[i]) begin
            rx_fc[i] = rx_sr[i][3:0];
            rx_q[i]  = rx_sr[i][7:4];
            if (load_cnt[i] < NREC) latch_w[i][load_cnt[i]] = {rx_q[i], rx_fc[i]};
            load_cnt[i]++;
         end
         if (done_w[i]) begin
            if (done_cnt[i] < NREC) done_cyc[i][done_cnt[i]] = cyc;
            done_cnt[i]++;
         end
         rx_psck[i]  = sck_w[i];
         rx_pload[i] = load_w[i];
         prev_sdi[i] = sdi_w[i];
      end
   end

   // ---------------- stimulus helpers -----------------------------------------
   // Returns the cycle whose closing edge accepted the word.
   task automatic send(input int i, input logic [7:0] w, output int acc);
      int n;
      acc = -1;
      n   = 0;
      @(posedge clk); #1;
      drv_valid[i] = 1'b1;
      drv_q[i]     = w[7:4];
      drv_fc[i]    = w[3:0];
      while (acc < 0 && n < 500) begin
         @(negedge clk);
         if (rdy[i]) acc = cyc;
         @(posedge clk); #1;
         n++;
      end
      drv_valid[i] = 1'b0;
      if (acc < 0) check("send_accepted", 0, 1);
   endtask

   task automatic wait_done(input int i, input int budget, output int d);
      int n;
      d = -1;
      n = 0;
      while (d < 0 && n < budget) begin
         @(negedge clk);
         if (done_w[i]) d = cyc;
         n++;
      end
      if (d < 0) check("done_seen", 0, 1);
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_w[i] || !rdy[i]) && n < 3000);
      check($sformatf("idle_reached%0d", i), 32'(busy_w[i]), 0);
   endtask

   // ---------------- directed sequence ----------------------------------------
   initial begin
      int         a, a2, a3, d, n, r0, l0, d0;
      logic [7:0] w;
      for (int i = 0; i < 2; i++) begin
         drv_valid[i] = 1'b0;
         drv_fc[i]    = 4'h0;
         drv_q[i]     = 4'h0;
      end

      // Reset values: everything low except wr_ready.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++)
         check($sformatf("reset_outs%0d", i),
               32'({rdy[i], sdi_w[i], sck_w[i], load_w[i], busy_w[i], done_w[i]}), 'h20);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // One word, HALF=2, fc=A q=3: frame 0x3A -> sdi 0,0,1,1,1,0,1,0.
      r0 = rise_cnt[0];
      l0 = load_cnt[0];
      send(0, 8'h3A, a);
      wait_done(0, 200, d);
      check("t1_done_latency", d - a, 37);
      repeat (2) @(negedge clk);
      check("t1_sck_rises", rise_cnt[0] - r0, 8);
      check("t1_load_rises", load_cnt[0] - l0, 1);
      check("t1_sdi_bits", 32'(rx_sr[0]), 'h3A);
      check("t1_first_rise", rise_cyc[0][r0] - a, 3);
      check("t1_fc_reg", 32'(rx_fc[0]), 'hA);
      check("t1_q_reg", 32'(rx_q[0]), 'h3);

      // Loopback sweep fc=0..15, q=15-fc, streamed through the buffer.
      l0 = load_cnt[0];
      for (int f = 0; f < 16; f++) begin
         w = {4'(15 - f), 4'(f)};
         send(0, w, a);
      end
      n = 0;
      while (load_cnt[0] < l0 + 16 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t2_loads", load_cnt[0] - l0, 16);
      for (int f = 0; f < 16; f++) begin
         w = {4'(15 - f), 4'(f)};
         check($sformatf("t2_word%0d", f), 32'(latch_w[0][l0 + f]), 32'(w));
      end
      wait_idle(0);

      // Back to back 5C, C5, then a third word while the buffer is full.
      d0 = done_cnt[0];
      l0 = load_cnt[0];
      send(0, 8'h5C, a);
      send(0, 8'hC5, a2);
      @(negedge clk);
      check("t3_ready_low", 32'(rdy[0]), 0);
      send(0, 8'h96, a3);
      check("t3_third_accept", a3 - a, 37);
      n = 0;
      while (done_cnt[0] < d0 + 3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("t3_dones", done_cnt[0] - d0, 3);
      check("t3_done1", done_cyc[0][d0] - a, 37);
      check("t3_two_frames", done_cyc[0][d0 + 1] - a - 1, 72);
      check("t3_done3", done_cyc[0][d0 + 2] - a, 109);
      check("t3_word1", 32'(latch_w[0][l0]), 'h5C);
      check("t3_word2", 32'(latch_w[0][l0 + 1]), 'hC5);
      check("t3_word3", 32'(latch_w[0][l0 + 2]), 'h96);
      wait_idle(0);

      // Reset during bit 4 (SCK high) of frame A5.
      l0 = load_cnt[0];
      send(0, 8'hA5, a);
      while (cyc < a + 19) @(negedge clk);
      check("t4_bit4_sck_high", 32'(sck_w[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_sck_drop", 32'(sck_w[0]), 0);
      check("t4_load_low", 32'(load_w[0]), 0);
      check("t4_busy_drop", 32'(busy_w[0]), 0);
      check("t4_ready_high", 32'(rdy[0]), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("t4_no_load_edge", load_cnt[0] - l0, 0);
      check("t4_fc_kept", 32'(rx_fc[0]), 'h6);
      check("t4_q_kept", 32'(rx_q[0]), 'h9);

      // HALF=5 instance: frame C3 is 90 cycles, SCK period 10.
      r0 = rise_cnt[1];
      l0 = load_cnt[1];
      send(1, 8'hC3, a);
      wait_done(1, 300, d);
      check("t5_done_latency", d - a, 91);
      repeat (2) @(negedge clk);
      check("t5_sck_rises", rise_cnt[1] - r0, 8);
      check("t5_first_rise", rise_cyc[1][r0] - a, 6);
      for (int k = 1; k < 8; k++)
         check($sformatf("t5_sck_period%0d", k), rise_cyc[1][r0 + k] - rise_cyc[1][r0 + k - 1], 10);
      check("t5_word", 32'(latch_w[1][l0]), 'hC3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/svf_bias_spi_tx.md
# svf_bias_spi_tx

Serial transmitter for the SVF bias-DAC control port: it takes a parallel {Q, fc} word and drives the three-wire SDI/SCK/LOAD frame that the chip's bias shift register expects. SCK rises once per bit, MSB first, and LOAD rises once after the eighth bit. It sits on the host/FPGA side of the link, or in the on-chip self-test wrapper, and feeds uio_in[4:2] of the filter top level. A one-entry holding buffer lets a caller queue the next setting while the current frame is still shifting.

## Interface
- HALF, default 2: clk cycles per SCK/LOAD phase. Legal range 2..255, checked at elaboration.
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- wr_valid  input  1  a new word is offered on wr_fc/wr_q.
- wr_ready  output  1  the transmitter can accept a word this cycle.
- wr_fc  input  4  fc code; bits [3:0] of the frame.
- wr_q  input  4  Q code; bits [7:4] of the frame.
- sdi  output  1  serial data, driven to uio_in[4].
- sck  output  1  serial clock, driven to uio_in[3].
- load  output  1  latch strobe, driven to uio_in[2].
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Handshake: a word is accepted on any rising edge where wr_valid && wr_ready. wr_ready = !pend_valid, so it is also high in IDLE.
- Frame word = {wr_q, wr_fc}. Bits go out 7 down to 0, so q[3] is sent first and fc[0] last.
- FSM states: IDLE, BIT_LO, BIT_HI, GAP, LOAD. Each non-IDLE state lasts exactly HALF cycles, counted by a phase timer.
- IDLE:
  - On accept, go to BIT_LO with shift register = word and bit counter = 7.
  - If pend_valid is set, start from the pending word instead.
- BIT_LO: sck=0, sdi=shift[7]. Then go to BIT_HI.
- BIT_HI: sck=1, sdi unchanged. Then:
  - if bit counter ≠ 0: shift left, decrement the counter, go to BIT_LO;
  - if bit counter = 0: go to GAP.
- GAP: sck=0, sdi=0, load=0. Then go to LOAD.
- LOAD: load=1. At its end:
  - pulse done;
  - if pend_valid: take the pending word and go straight to BIT_LO;
  - otherwise go to IDLE.
- Accepting while busy writes the holding buffer and sets pend_valid. pend_valid clears when the buffer is consumed.
- Simultaneous events: if the buffer is consumed and a new word is accepted in the same cycle, the new word refills the buffer and pend_valid stays 1.
- IDLE outputs: sck=0, sdi=0, load=0, busy=0.
- busy=1 in every non-IDLE state.
- sdi only changes while sck=0. load is never 1 while sck=1.

## Timing
- Reset values: sdi=0, sck=0, load=0, busy=0, done=0, wr_ready=1. Reset also clears pend_valid, the state, the counters and the shift register.
- Reset asserted mid-frame: sck and load drop in the same instant, and the pending word is discarded. A partial frame never produces a LOAD rising edge.
- All outputs are registered, with no combinational path from inputs to outputs except wr_ready, which comes from a register.
- Latency: a word accepted at edge t shows sck=0 with sdi = q[3] from t+1.
  - First SCK rise: t+1+HALF.
  - Frame length: 18·HALF cycles (16·HALF bit phases, HALF GAP, HALF LOAD).
  - done is high for the one cycle after the last LOAD cycle: t+1+18·HALF.
- Back-to-back frames: with a word pending, the next BIT_LO begins in the same cycle that done is high. There are no idle cycles, and load falls at that same point.
- Minimum HALF is 2 because the receiver edge-detects SCK and LOAD with clk-sampled levels. Each level must hold for at least 2 receiver clk cycles, including across asynchronous clock domains.

## Structure
- The shared package svf_ctrl_pkg holds:
  - FRAME_BITS = 8, FC_BITS = 4, Q_BITS = 4;
  - the state enum {IDLE, BIT_LO, BIT_HI, GAP, LOAD};
  - a frame-packing function returning {q, fc}.
- One sub-module, svf_phase_timer, holds the phase logic: a HALF-cycle down-counter with a restart input and a one-cycle expire output.
- The FSM, bit counter, shift register and holding buffer live in the top module.

## Test plan
- Reset, then one word with HALF=2, fc=4'hA, q=4'h3:
  - SDI sampled at each SCK rise reads 0,0,1,1,1,0,1,0;
  - exactly 8 SCK rises, then 1 LOAD rise;
  - done at t+37.
- Loopback through a behavioural copy of the bias shift-register receiver: sweep fc over 0..15 with q = 15−fc; the latched fc_reg/q_reg match every word.
- Back-to-back words 8'h5C then 8'hC5, with the second offered while busy:
  - wr_ready falls after the second accept;
  - the frames are contiguous, 72 cycles total;
  - exactly 2 done pulses.
- Third word offered while the buffer is full is held until wr_ready rises in the cycle of the first done; it is accepted then with no loss.
- rst_n pulled low in bit 4 of a frame: sck, load and busy go to 0 immediately; no LOAD edge; the receiver registers are unchanged.
- HALF=5: every SCK high and low phase is 5 cycles and the frame is 90 cycles; an assertion checks that sdi is stable while sck=1 and that load & sck is never true.
